mult_seq_32: RTL and testbench
==============================

# mult_seq_32

Sequential 32x32 shift-add multiplier for the Phase 2 datapath. Accepts two 32-bit operands on a start pulse and computes the 64-bit product one bit per cycle, signed or unsigned. It presents the upper and lower halves on `hi` and `lo` with a one-cycle `done` strobe. `hi`, `lo` and `done` connect directly to the `inp` and `write` inputs of the HI and LO 32-bit registers downstream.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- start  in  1  request; sampled only when idle.
- signed_op  in  1  1 = two's-complement multiply, 0 = unsigned; sampled with start.
- a  in  32  multiplicand; latched with start.
- b  in  32  multiplier; latched with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle strobe; hi/lo valid; drives HI/LO register write.
- hi  out  32  product bits [63:32].
- lo  out  32  product bits [31:0].

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1: latch operands.
  - If signed_op, latch |a| and |b| as 32-bit unsigned magnitudes. |0x80000000| = 0x80000000, which fits.
  - Record `neg = signed_op & (a[31] ^ b[31])`.
  - Clear the 64-bit accumulator and the 6-bit counter, then go to CALC.
- IDLE, start=0: remain in IDLE.
- CALC, each cycle: if multiplier LSB = 1, add the multiplicand to the accumulator. Shift the multiplier right by 1, shift the multiplicand left by 1, and increment the counter.
  - After 32 CALC cycles (counter reaches 31 and that iteration completes), go to FIX.
- FIX: if neg, replace the accumulator with its 64-bit two's-complement negation. Load hi/lo from the result and go to DONE.
- DONE: done=1 for this cycle only, then go to IDLE.
- busy = 1 in CALC and FIX, and 0 in IDLE and DONE.
- start asserted while busy=1 is ignored; no queuing.
- start asserted in the DONE cycle is ignored, because the block is not in IDLE. The earliest next accept is the cycle after done.
- Operand, signed_op and start changes after the accepting edge have no effect on the running operation.
- hi/lo hold the last result until the next FIX overwrites them. They are not cleared at start.
- Arithmetic is exact. The unsigned result ranges over 0..(2^32-1)^2, and the signed range is covered by the magnitude-plus-negate method. No overflow is possible.

## Timing
- Reset (reset=1 at any edge, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, and the counter and accumulator are cleared.
  - An operation in progress is abandoned; no done is produced.
  - reset has priority over start in the same cycle.
- Let edge E0 be the edge that samples start=1 in IDLE.
  - busy=1 after E0.
  - E1..E32 perform the 32 CALC iterations.
  - E33 performs FIX, loads hi/lo and sets done=1, busy=0.
  - E34 clears done.
- Latency: done is visible 33 cycles after the accepting edge. Throughput is one result per 35 cycles at most.
- done and the new hi/lo values become visible on the same edge. A downstream register sampling on done captures the new value at E34.

## Test plan
- Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF, signed_op=0, start for 1 cycle -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- Signed mixed: a=0xFFFFFFFD (-3), b=5, signed_op=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also a=0xFFFFFFFF, b=0xFFFFFFFF, signed_op=1 -> hi=0, lo=1.
- Signed min corner: a=b=0x80000000, signed_op=1 -> hi=0x40000000, lo=0x00000000. Unsigned -> hi=0x40000000, lo=0.
- Ignore while busy:
  - Start a=7, b=6; pulse start with a=9, b=9 at cycle 10 -> single done, lo=42.
  - Hold start high continuously -> second operation accepted the cycle after done.
- Reset mid-operation: start a=3, b=4; assert reset at cycle 15 -> busy=0, done=0, hi=lo=0, and no done ever appears. Then a new start a=2, b=0 -> done after 33 cycles with hi=lo=0.
- Result hold: after a=10, b=10 completes (lo=100), idle 50 cycles -> lo stays 100 and done stays 0.

Source files
------------

// File: rtl/mult_seq_32.sv
// Sequential 32x32 shift-add multiplier, one product bit per cycle, signed or unsigned.
// done strobes 33 cycles after the accepting edge; start is ignored unless idle.
module mult_seq_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic        neg;
  logic [31:0] a_mag, b_mag;

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude
  assign a_mag = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (signed_op && b[31]) ? (~b + 32'd1) : b;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == 6'd31) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= 64'd0;
      mplier <= 32'd0;
      acc    <= 64'd0;
      cnt    <= 6'd0;
      neg    <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            neg    <= signed_op & (a[31] ^ b[31]);
            acc    <= 64'd0;
            cnt    <= 6'd0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + 6'd1;
        end
        FIX: begin
          {hi, lo} <= neg ? (~acc + 64'd1) : acc;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_seq_32.sv
// Bench for mult_seq_32: cycle-level reference model compared every cycle, plus directed literal cases.
module tb_mult_seq_32;

  logic        clk = 1'b0;
  logic        reset, start, signed_op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_seq_32 dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: -1 when idle, otherwise cycles elapsed since the accepting edge.
  int          m_since = -1;
  logic [63:0] m_prod = 64'd0;
  logic [63:0] m_out  = 64'd0;
  bit          cmp_en = 1'b0;

  function automatic logic [63:0] product(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_since = -1;
      m_out   = 64'd0;
    end else if (m_since == -1) begin
      if (start) begin
        m_since = 0;
        m_prod  = product(a, b, signed_op);
      end
    end else begin
      m_since = m_since + 1;
      if (m_since == 33) m_out = m_prod;
      if (m_since == 34) m_since = -1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_since >= 0 && m_since <= 32));
      chk("cyc_done", 64'(done), 64'(m_since == 33));
      chk("cyc_hilo", {hi, lo}, m_out);
    end
  end

  task automatic pulse_start(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    @(posedge clk); #1;
    a = ta; b = tb_v; signed_op = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic [31:0] eh, input logic [31:0] el,
                        output int busy_n);
    bit seen;
    seen = 1'b0;
    busy_n = 0;
    pulse_start(ta, tb_v, ts);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_hilo"}, {hi, lo}, {eh, el});
    chk({nm, "_model"}, m_prod, {eh, el});
  endtask

  int bn, dn, gap;
  bit got;

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", {31'd0, busy, done, hi, lo}, 66'd0);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, bn);
    chk("umax_busy_cycles", 64'(bn), 64'd33);
    run_op("s_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, bn);
    run_op("s_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1, bn);
    run_op("s_min", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, bn);
    run_op("u_min", 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0, bn);
    run_op("s_minx1", 32'h80000000, 32'd1, 1'b1, 32'hFFFFFFFF, 32'h80000000, bn);

    // second start while busy must be dropped
    pulse_start(32'd7, 32'd6, 1'b0);
    repeat (8) @(posedge clk);
    #1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dn = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("ignore_busy_dones", 64'(dn), 64'd1);
    chk("ignore_busy_hilo", {hi, lo}, 64'd42);

    // start held high: next accept is the cycle after done
    @(posedge clk); #1;
    a = 32'd2; b = 32'd3; signed_op = 1'b0; start = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("hold_first_done", 64'(got), 64'd1);
    got = 1'b0; gap = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      gap++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("hold_second_done", 64'(got), 64'd1);
    chk("hold_gap", 64'(gap), 64'd35);
    chk("hold_hilo", {hi, lo}, 64'd6);

    // reset mid-operation abandons the product
    pulse_start(32'd3, 32'd4, 1'b0);
    repeat (13) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midreset_state", {31'd0, busy, done, hi, lo}, 66'd0);
    dn = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midreset_no_done", 64'(dn), 64'd0);
    run_op("zero", 32'd2, 32'd0, 1'b0, 32'd0, 32'd0, bn);

    // result holds while idle
    run_op("ten", 32'd10, 32'd10, 1'b0, 32'd0, 32'd100, bn);
    dn = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("hold_idle_done", 64'(dn), 64'd0);
    chk("hold_idle_lo", 64'(lo), 64'd100);

    // a few model-only vectors, checked by the per-cycle compare
    for (int i = 0; i < 6; i++) begin
      pulse_start($urandom, $urandom, 1'(i % 2));
      repeat (36) @(posedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
